// File: rtl/roughness_estimator_pkg.sv
// roughness_estimator_pkg: shared widths, defaults and result saturation
package roughness_estimator_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int WIN_LOG2_DEF = 6;
  localparam int DC_SHIFT_DEF = 8;
  localparam int ENV_W = DATA_WIDTH + 1;
  localparam int ACC_W = ENV_W + WIN_LOG2_DEF;
  function automatic logic [DATA_WIDTH-1:0] sat_u16(input logic [31:0] v);
    return v > 32'(16'hFFFF) ? '1 : v[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/dc_remover.sv
// dc_remover: IIR DC tracker producing the offset-free 17-bit sample
module dc_remover
  import roughness_estimator_pkg::*;
#(
  parameter int DC_SHIFT = DC_SHIFT_DEF
) (
  input logic clk,
  input logic reset,
  input logic sample_en,
  input logic [DATA_WIDTH-1:0] audio_in,
  output logic signed [ENV_W-1:0] y
);
  logic signed [DATA_WIDTH+DC_SHIFT:0] dc_acc;
  logic signed [ENV_W-1:0] dc;
  always_comb begin
    dc = dc_acc[DATA_WIDTH+DC_SHIFT:DC_SHIFT];
    y = {audio_in[DATA_WIDTH-1], audio_in} - dc;
  end
  always_ff @(posedge clk)
    if (reset) dc_acc <= '0;
    else if (sample_en) dc_acc <= dc_acc + {{DC_SHIFT{y[ENV_W-1]}}, y};
endmodule

// File: rtl/roughness_estimator.sv
// roughness_estimator: windowed mean of envelope sample-to-sample fluctuation
module roughness_estimator
  import roughness_estimator_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int DC_SHIFT = DC_SHIFT_DEF
) (
  input logic clk,
  input logic reset,
  input logic sample_en,
  input logic [DATA_WIDTH-1:0] audio_in,
  output logic [DATA_WIDTH-1:0] roughness_out,
  output logic roughness_valid
);
  localparam int SUM_W = ENV_W + WIN_LOG2;
  logic signed [ENV_W-1:0] y;
  logic [ENV_W-1:0] env, env_prev, diff;
  logic [SUM_W-1:0] acc, sum;
  logic [WIN_LOG2-1:0] cnt;
  logic win_end;
  dc_remover #(.DC_SHIFT(DC_SHIFT)) u_dc (
    .clk(clk),
    .reset(reset),
    .sample_en(sample_en),
    .audio_in(audio_in),
    .y(y)
  );
  always_comb begin
    env = y[ENV_W-1] ? -y : y;
    diff = env >= env_prev ? env - env_prev : env_prev - env;
    sum = acc + SUM_W'(diff);
    win_end = &cnt;
  end
  always_ff @(posedge clk)
    if (reset) begin
      env_prev <= '0;
      acc <= '0;
      cnt <= '0;
      roughness_out <= '0;
      roughness_valid <= 1'b0;
    end else begin
      roughness_valid <= sample_en && win_end;
      if (sample_en) begin
        env_prev <= env;
        cnt <= cnt + WIN_LOG2'(1);
        acc <= win_end ? '0 : sum;
        if (win_end) roughness_out <= sat_u16(32'(sum >> WIN_LOG2));
      end
    end
endmodule

// File: tb/tb_roughness_estimator.sv
// tb_roughness_estimator: table-driven and randomized check against an integer model
module tb_roughness_estimator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_en = 1'b0;
  logic [15:0] audio_in = '0;
  logic [15:0] roughness_out;
  logic roughness_valid;
  int checks = 0;
  int errors = 0;
  longint m_dc_acc, m_env_prev, m_acc, m_out;
  int m_n;
  bit exp_valid;
  int results[$];
  typedef struct {
    int pat;
    int nwin;
    int gap;
    int lo1;
    int hi1;
    int lo2;
    int hi2;
  } scen_t;
  scen_t tbl[5];
  roughness_estimator dut (
    .clk(clk),
    .reset(reset),
    .sample_en(sample_en),
    .audio_in(audio_in),
    .roughness_out(roughness_out),
    .roughness_valid(roughness_valid)
  );
  always #5 clk = ~clk;
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected range [%0d,%0d]", name, act, lo, hi);
    end
  endtask
  function automatic int pat_val(input int pat, input int i);
    int p4[4];
    int f4[4];
    p4 = '{1000, -1000, 0, 0};
    f4 = '{32767, -32768, 0, 0};
    case (pat)
      1: return 1000;
      2: return (i % 2 == 0) ? 1000 : -1000;
      3: return p4[i % 4];
      4: return f4[i % 4];
      default: return 0;
    endcase
  endfunction
  task automatic model_sample(input int x);
    longint dc, yv, env, d, s;
    dc = m_dc_acc >>> 8;
    yv = x - dc;
    env = yv < 0 ? -yv : yv;
    d = env > m_env_prev ? env - m_env_prev : m_env_prev - env;
    s = m_acc + d;
    m_dc_acc += yv;
    m_env_prev = env;
    m_n++;
    if (m_n == 64) begin
      m_out = (s / 64 > 65535) ? 65535 : s / 64;
      m_acc = 0;
      m_n = 0;
      exp_valid = 1'b1;
    end else m_acc = s;
  endtask
  task automatic step(input bit en, input int x);
    sample_en = en;
    audio_in = 16'(x);
    @(posedge clk);
    exp_valid = 1'b0;
    if (en) model_sample(x);
    @(negedge clk);
    chk("valid", roughness_valid, exp_valid);
    chk("out", roughness_out, m_out);
    if (roughness_valid) results.push_back(int'(roughness_out));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    sample_en = 1'b1;
    audio_in = 16'd1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sample_en = 1'b0;
    m_dc_acc = 0;
    m_env_prev = 0;
    m_acc = 0;
    m_out = 0;
    m_n = 0;
    results.delete();
    chk("reset_out", roughness_out, 0);
    chk("reset_valid", roughness_valid, 0);
  endtask
  initial begin
    tbl[0] = '{0, 1, 3, 0, 0, 0, 0};
    tbl[1] = '{1, 5, 0, 15, 25, 0, 10};
    tbl[2] = '{2, 3, 0, 15, 18, 0, 2};
    tbl[3] = '{3, 3, 1, 490, 510, 490, 510};
    tbl[4] = '{4, 3, 0, 16000, 16800, 16000, 16800};
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      do_reset();
      for (int i = 0; i < tbl[t].nwin * 64; i++) begin
        step(1'b1, pat_val(tbl[t].pat, i));
        for (int g = 0; g < tbl[t].gap; g++) step(1'b0, 0);
      end
      step(1'b0, 0);
      chk($sformatf("pulses_p%0d", tbl[t].pat), results.size(), tbl[t].nwin);
      for (int w = 0; w < results.size(); w++)
        if (w == 0) rng($sformatf("win_p%0d_w%0d", tbl[t].pat, w), results[w], tbl[t].lo1, tbl[t].hi1);
        else rng($sformatf("win_p%0d_w%0d", tbl[t].pat, w), results[w], tbl[t].lo2, tbl[t].hi2);
      if (tbl[t].pat == 1)
        for (int w = 1; w < results.size(); w++)
          rng($sformatf("decay_w%0d", w), results[w], 0, results[w-1]);
    end
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, pat_val(3, i));
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 0);
    step(1'b0, 0);
    chk("midreset_pulses", results.size(), 1);
    if (results.size() > 0) chk("midreset_val", results[0], 0);
    do_reset();
    for (int i = 0; i < 4 * 64; i++) begin
      step(1'b1, int'($signed(16'($urandom))));
      repeat ($urandom_range(0, 2)) step(1'b0, 0);
    end
    step(1'b0, 0);
    chk("rand_pulses", results.size(), 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/roughness_estimator.md
Name: roughness_estimator

Overview:
- Streaming audio-feature block in the I2S capture chain, after the FIFO and beside the ZCR/STE feature blocks.
- Takes 16-bit signed PCM samples and removes their DC offset.
- Measures sample-to-sample fluctuation of the rectified envelope, averaged over fixed windows. This is the roughness (amplitude-modulation) metric.
- Emits one 16-bit result per window. Vendor global set/reset primitives (GSR/PUR) are not part of this block; all state is cleared by the explicit `reset` port.

Parameters:
- DATA_WIDTH, 16, sample and result width.
- WIN_LOG2, 6, log2 of window length N in samples (N = 64).
- DC_SHIFT, 8, DC-tracker IIR coefficient 2^-DC_SHIFT.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- sample_en  input  1  one-cycle strobe; audio_in is accepted on a clk edge where it is high.
- audio_in  input  16  signed two's-complement PCM sample.
- roughness_out  output  16  unsigned roughness of last completed window; held between windows.
- roughness_valid  output  1  high for exactly one cycle when roughness_out updates.

Behaviour:
- Reset: roughness_out=0, roughness_valid=0, dc_acc=0, env_prev=0, acc=0, cnt=0.
- sample_en low: no register changes; roughness_valid=0.
- On sample_en high, evaluate combinationally from current state:
  - dc = dc_acc >>> DC_SHIFT. dc_acc is signed, DATA_WIDTH+DC_SHIFT+1 bits.
  - y = audio_in − dc, 17-bit signed, no saturation.
  - env = |y|, 17-bit unsigned, maximum 65536.
  - diff = |env − env_prev|, 17-bit unsigned.
  - sum = acc + diff. acc is unsigned, 17+WIN_LOG2 bits, and never overflows.
- Registered on the same edge:
  - dc_acc <= dc_acc + audio_in − dc.
  - env_prev <= env.
  - cnt <= cnt+1, wrapping modulo N.
- Window end (cnt == N−1 at the accepting edge):
  - roughness_out <= min(sum >> WIN_LOG2, 65535).
  - acc <= 0; roughness_valid <= 1 on the next cycle only.
- Otherwise: acc <= sum; roughness_out holds.
- Latency: result visible one clk after the edge accepting the N-th sample of a window.
- First sample after reset uses env_prev=0, so the first window includes env of sample 0 as a diff.
- sample_en high on consecutive cycles is legal, giving full throughput of one sample per clk.
- Reset asserted mid-window aborts the window; reset wins over a simultaneous sample_en.
- Arithmetic is sign-extended throughout; only the final result is saturated.

Decomposition:
- Shared package:
  - DATA_WIDTH.
  - Default WIN_LOG2 and DC_SHIFT.
  - Derived widths (ENV_W=17, ACC_W=ENV_W+WIN_LOG2).
  - An unsigned saturate-to-16 function.
- One natural sub-module: dc_remover. Holds dc_acc; inputs sample_en/audio_in; outputs the 17-bit y combinationally.
- Envelope, difference, accumulate and window counter stay in the top.

Test Plan:
- Reset, then 64 samples of 0 with sample_en every 4th clk: exactly one valid pulse, after the 64th sample, with roughness_out=0. No pulse at any other time.
- Reset, then constant +1000 for 5 windows: first window ≥15 (initial env step 1000/64). Later windows decay monotonically toward 0 as dc converges.
- Reset, then alternating +1000/−1000 for 3 windows (dc stays within ±8): window 1 = 15±1, windows 2–3 = 0±1.
- Reset, then repeating pattern +1000, −1000, 0, 0 for 3 windows: windows 2–3 = 500±4.
- Reset, then alternating 32767/−32768 plus 0 pattern: no wrap; roughness_out ≤ 65535 and consistent with a reference model.
- Assert reset after 40 samples of the +1000,−1000,0,0 pattern, then feed 64 zeros: no pulse until 64 post-reset samples; result 0, proving acc and cnt were cleared.
